// File: rtl/rf_pkg.sv
// rf_pkg: shared constants and width-derivation helpers for the register
// file bank and its busy-bit scoreboard.
//   DEF_BUS_WIDTH / DEF_NUM_REGS : default parameter values
//   addr_w(n) : select width for n registers (n a power of two, n >= 2)
//   cnt_w(n)  : width of a counter that must hold 0..n inclusive
package rf_pkg;

    localparam int DEF_BUS_WIDTH = 16;
    localparam int DEF_NUM_REGS  = 8;

    function automatic int addr_w(input int n);
        return $clog2(n);
    endfunction

    // One extra bit so "every register busy" (== n) is representable.
    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: one busy bit per register plus a running count of busy
// registers. A set marks a register as having an outstanding producer; a
// clear retires it. When both hit the same register on one edge the set
// wins, because the newer producer is still outstanding.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   set_en, set_idx    mark register set_idx busy
//   clr_en, clr_idx    mark register clr_idx not busy
//   busy               per-register busy bits (registered)
//   busy_cnt           number of set bits in busy (registered)
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter  int NUM_REGS = DEF_NUM_REGS,
    localparam int ADDR_W   = addr_w(NUM_REGS),
    localparam int CNT_W    = cnt_w(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                set_en,
    input  logic [ADDR_W-1:0]   set_idx,
    input  logic                clr_en,
    input  logic [ADDR_W-1:0]   clr_idx,
    output logic [NUM_REGS-1:0] busy,
    output logic [CNT_W-1:0]    busy_cnt
);

    logic [NUM_REGS-1:0] busy_nxt;
    logic                inc;
    logic                dec;

    always_comb begin
        busy_nxt = busy;
        if (clr_en) busy_nxt[clr_idx] = 1'b0;
        if (set_en) busy_nxt[set_idx] = 1'b1;
    end

    // The count moves only on real 0->1 / 1->0 transitions, so re-issuing a
    // busy register or writing an idle one leaves it unchanged. A clear that
    // collides with a set on the same register is cancelled by the set.
    assign inc = set_en && !busy[set_idx];
    assign dec = clr_en && busy[clr_idx] && !(set_en && (set_idx == clr_idx));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= busy_cnt + CNT_W'(inc) - CNT_W'(dec);
        end
    end

endmodule

// File: rtl/rf_bank_sb.sv
// rf_bank_sb: register file with two registered read ports, one writeback
// port and a busy-bit scoreboard for hazard reporting.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en, rd, D      writeback strobe / destination / data
//   iss_en, iss_rd    issue strobe / destination marked busy
//   rd_en, rsA, rsB   read strobe and source selects for both ports
//   A, B              registered read data (held while rd_en=0)
//   hazA, hazB        registered "source pending" flags
//   busy_cnt          number of busy registers
module rf_bank_sb
    import rf_pkg::*;
#(
    parameter  int BUS_WIDTH = DEF_BUS_WIDTH,
    parameter  int NUM_REGS  = DEF_NUM_REGS,
    parameter  int ZERO_REG  = 0,
    localparam int ADDR_W    = addr_w(NUM_REGS),
    localparam int CNT_W     = cnt_w(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    rd,
    input  logic [BUS_WIDTH-1:0] D,
    input  logic                 iss_en,
    input  logic [ADDR_W-1:0]    iss_rd,
    input  logic                 rd_en,
    input  logic [ADDR_W-1:0]    rsA,
    input  logic [ADDR_W-1:0]    rsB,
    output logic [BUS_WIDTH-1:0] A,
    output logic [BUS_WIDTH-1:0] B,
    output logic                 hazA,
    output logic                 hazB,
    output logic [CNT_W-1:0]     busy_cnt
);

    logic [NUM_REGS-1:0][BUS_WIDTH-1:0] regs;
    logic [NUM_REGS-1:0]                busy;
    logic                               wr_ok;
    logic                               iss_ok;
    logic                               byp_a;
    logic                               byp_b;

    // With ZERO_REG set, register 0 is never written and never marked busy,
    // so it stays at its reset value of 0 with a clear busy bit. Reads of it
    // then naturally return 0/haz=0, and bypass cannot fire because wr_ok
    // is already suppressed.
    assign wr_ok  = wr_en  && !((ZERO_REG != 0) && (rd     == '0));
    assign iss_ok = iss_en && !((ZERO_REG != 0) && (iss_rd == '0));

    assign byp_a = wr_ok && (rd == rsA);
    assign byp_b = wr_ok && (rd == rsB);

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (iss_ok),
        .set_idx  (iss_rd),
        .clr_en   (wr_ok),
        .clr_idx  (rd),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else if (wr_ok) begin
            regs[rd] <= D;
        end
    end

    // Both ports use identical logic, so rsA == rsB yields identical results.
    // A bypassed source reports no hazard: the value being written is the
    // one the reader is waiting for.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A    <= '0;
            B    <= '0;
            hazA <= 1'b0;
            hazB <= 1'b0;
        end else if (rd_en) begin
            A    <= byp_a ? D    : regs[rsA];
            hazA <= byp_a ? 1'b0 : busy[rsA];
            B    <= byp_b ? D    : regs[rsB];
            hazB <= byp_b ? 1'b0 : busy[rsB];
        end
    end

endmodule

// File: tb/tb_rf_bank_sb.sv
// tb_rf_bank_sb: directed bench for rf_bank_sb. Two instances share every
// input: u_dut (ZERO_REG=0) and u_dz (ZERO_REG=1). Expected values are
// hand-computed constants.
module tb_rf_bank_sb;

    localparam int BW = 16;
    localparam int NR = 8;
    localparam int AW = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en, iss_en, rd_en;
    logic [AW-1:0] rd, iss_rd, rsA, rsB;
    logic [BW-1:0] D;

    logic [BW-1:0] a0, b0, a1, b1;
    logic          ha0, hb0, ha1, hb1;
    logic [CW-1:0] cnt0, cnt1;

    int vec  = 0;
    int miss = 0;

    always #5 clk = ~clk;

    rf_bank_sb #(.BUS_WIDTH(BW), .NUM_REGS(NR), .ZERO_REG(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd(rd), .D(D),
        .iss_en(iss_en), .iss_rd(iss_rd), .rd_en(rd_en), .rsA(rsA), .rsB(rsB),
        .A(a0), .B(b0), .hazA(ha0), .hazB(hb0), .busy_cnt(cnt0)
    );

    rf_bank_sb #(.BUS_WIDTH(BW), .NUM_REGS(NR), .ZERO_REG(1)) u_dz (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd(rd), .D(D),
        .iss_en(iss_en), .iss_rd(iss_rd), .rd_en(rd_en), .rsA(rsA), .rsB(rsB),
        .A(a1), .B(b1), .hazA(ha1), .hazB(hb1), .busy_cnt(cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; iss_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0; iss_en = 1'b0; rd_en = 1'b0;
        rd = '0; iss_rd = '0; rsA = '0; rsB = '0; D = '0;
        tick(); tick();
        chk("rst A", 32'(a0), 0);
        chk("rst B", 32'(b0), 0);
        chk("rst haz", 32'({ha0, hb0, ha1, hb1}), 0);
        chk("rst cnt", 32'(cnt0), 0);
        chk("rst cnt z", 32'(cnt1), 0);
        rst_n = 1'b1;

        // Read every register after reset.
        for (int i = 0; i < NR; i++) begin
            rd_en = 1'b1; rsA = AW'(i); rsB = AW'(NR - 1 - i);
            tick();
            chk("init rd A", 32'(a0), 0);
            chk("init rd B", 32'(b0), 0);
            chk("init rd haz", 32'({ha0, hb0}), 0);
        end
        chk("init cnt", 32'(cnt0), 0);

        // Write BEEF to r3, read it on both ports next cycle.
        idle(); wr_en = 1'b1; rd = 3'd3; D = 16'hBEEF;
        tick();
        idle(); rd_en = 1'b1; rsA = 3'd3; rsB = 3'd3;
        tick();
        chk("r3 A", 32'(a0), 32'hBEEF);
        chk("r3 B", 32'(b0), 32'hBEEF);
        chk("r3 haz", 32'({ha0, hb0}), 0);
        // rd_en=0 holds the outputs.
        idle(); rsA = 3'd0; rsB = 3'd1;
        tick();
        chk("hold A", 32'(a0), 32'hBEEF);
        chk("hold B", 32'(b0), 32'hBEEF);

        // Issue r5, read it (hazard), then bypass the writeback.
        idle(); iss_en = 1'b1; iss_rd = 3'd5;
        tick();
        chk("iss5 cnt", 32'(cnt0), 1);
        idle(); rd_en = 1'b1; rsA = 3'd5; rsB = 3'd3;
        tick();
        chk("r5 hazA", 32'(ha0), 1);
        chk("r5 A", 32'(a0), 0);
        chk("r3 B no haz", 32'({b0, hb0}), 32'({16'hBEEF, 1'b0}));
        wr_en = 1'b1; rd = 3'd5; D = 16'h1234; rsA = 3'd5; rsB = 3'd5;
        tick();
        chk("byp A", 32'(a0), 32'h1234);
        chk("byp B", 32'(b0), 32'h1234);
        chk("byp haz", 32'({ha0, hb0}), 0);
        chk("byp cnt", 32'(cnt0), 0);
        idle(); rd_en = 1'b1; rsA = 3'd5; rsB = 3'd3;
        tick();
        chk("r5 stored", 32'({a0, ha0}), 32'({16'h1234, 1'b0}));

        // Issue and write r2 together: busy ends set, data stored.
        idle(); iss_en = 1'b1; iss_rd = 3'd2; wr_en = 1'b1; rd = 3'd2; D = 16'h5A5A;
        tick();
        chk("iss+wr cnt", 32'(cnt0), 1);
        idle(); iss_en = 1'b1; iss_rd = 3'd2;
        tick();
        chk("reiss cnt", 32'(cnt0), 1);
        idle(); rd_en = 1'b1; rsA = 3'd2; rsB = 3'd2;
        tick();
        chk("r2 A", 32'({a0, ha0}), 32'({16'h5A5A, 1'b1}));
        chk("r2 B", 32'({b0, hb0}), 32'({16'h5A5A, 1'b1}));
        // Issue r4 while retiring r2: net count change 0.
        idle(); iss_en = 1'b1; iss_rd = 3'd4; wr_en = 1'b1; rd = 3'd2; D = 16'h0F0F;
        tick();
        chk("swap cnt", 32'(cnt0), 1);
        // Write to idle r6: count unchanged.
        idle(); wr_en = 1'b1; rd = 3'd6; D = 16'h6666;
        tick();
        chk("idle wr cnt", 32'(cnt0), 1);
        idle(); wr_en = 1'b1; rd = 3'd4; D = 16'h4444;
        tick();
        chk("r4 retire cnt", 32'(cnt0), 0);
        idle(); rd_en = 1'b1; rsA = 3'd6; rsB = 3'd2;
        tick();
        chk("r6 A", 32'(a0), 32'h6666);
        chk("r2 new B", 32'({b0, hb0}), 32'({16'h0F0F, 1'b0}));

        // Register 0: ignored on u_dz, a normal register on u_dut.
        idle(); wr_en = 1'b1; rd = 3'd0; D = 16'hFFFF; iss_en = 1'b1; iss_rd = 3'd0;
        tick();
        chk("z0 cnt", 32'(cnt1), 0);
        chk("r0 cnt", 32'(cnt0), 1);
        idle(); rd_en = 1'b1; rsA = 3'd0; rsB = 3'd0;
        tick();
        chk("z0 A", 32'({a1, ha1}), 0);
        chk("z0 B", 32'({b1, hb1}), 0);
        chk("r0 A", 32'({a0, ha0}), 32'({16'hFFFF, 1'b1}));
        // Bypass to r0: still 0 on u_dz.
        wr_en = 1'b1; rd = 3'd0; D = 16'hAAAA;
        tick();
        chk("z0 byp A", 32'({a1, ha1}), 0);
        chk("r0 byp A", 32'({a0, ha0}), 32'({16'hAAAA, 1'b0}));
        chk("r0 byp cnt", 32'(cnt0), 0);

        // Fill the scoreboard, then reset mid-cycle.
        for (int i = 0; i < NR; i++) begin
            idle(); iss_en = 1'b1; iss_rd = AW'(i);
            tick();
        end
        chk("full cnt", 32'(cnt0), NR);
        chk("full cnt z", 32'(cnt1), NR - 1);
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk("arst A/B", 32'({a0, b0}), 0);
        chk("arst haz", 32'({ha0, hb0, ha1, hb1}), 0);
        chk("arst cnt", 32'({cnt0, cnt1}), 0);
        tick();
        rst_n = 1'b1;
        // First edge after release: normal bypassed read plus a stored read.
        wr_en = 1'b1; rd = 3'd1; D = 16'h0077; rd_en = 1'b1; rsA = 3'd1; rsB = 3'd3;
        tick();
        chk("post rst A", 32'({a0, ha0}), 32'({16'h0077, 1'b0}));
        chk("post rst r3", 32'({b0, hb0}), 0);
        chk("post rst cnt", 32'(cnt0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
